// File: rtl/decoder_seq.sv
// decoder_seq: registered N-to-2^N one-hot decoder with DIRECT (handshaked select) and SCAN (auto-step) modes.
// Latency: y/code/state/scan_wrap update one cycle after the deciding edge; sel_ready is combinational.
// Backpressure: sel_ready = en & ~mode, so a select is never stalled in DIRECT and is never taken in SCAN/OFF.
module decoder_seq #(
  parameter int SEL_W      = 2,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   y,
  output logic [SEL_W-1:0]      code,
  output logic [1:0]            state,
  output logic                  scan_wrap
);

  localparam int N    = 2**SEL_W;
  // Dwell counter needs at least one bit even when DWELL=1.
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CODE_MAX   = {SEL_W{1'b1}};
  localparam logic [N-1:0]     Y_INACTIVE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

  logic [DW_W-1:0]  dwell;
  logic [SEL_W-1:0] code_inc;

  // One-hot of c, inverted to one-cold when the outputs are active-low.
  function automatic logic [N-1:0] drive_y(input logic [SEL_W-1:0] c);
    logic [N-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  // Selects are only accepted while enabled and in DIRECT mode; rises the same cycle mode falls.
  assign sel_ready = en & ~mode;

  // Next scan code wraps naturally from max to 0 by truncation.
  assign code_inc = code + SEL_W'(1);

  // Mode/enable priority: reset, then disable, then DIRECT decode, then SCAN stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= Y_INACTIVE;
      code      <= '0;
      state     <= ST_OFF;
      scan_wrap <= 1'b0;
      dwell     <= '0;
    end else if (!en) begin
      // Code is kept so re-enabling resumes on the last selected output.
      y         <= Y_INACTIVE;
      state     <= ST_OFF;
      scan_wrap <= 1'b0;
      dwell     <= '0;
    end else if (!mode) begin
      state     <= ST_DIRECT;
      scan_wrap <= 1'b0;
      dwell     <= '0;
      if (sel_valid) begin
        code <= sel;
        y    <= drive_y(sel);
      end else begin
        y    <= drive_y(code);
      end
    end else begin
      state <= ST_SCAN;
      if (dwell == DWELL_LAST) begin
        dwell     <= '0;
        code      <= code_inc;
        y         <= drive_y(code_inc);
        scan_wrap <= (code == CODE_MAX);
      end else begin
        dwell     <= dwell + DW_W'(1);
        y         <= drive_y(code);
        scan_wrap <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed scoreboard bench for two decoder_seq configurations.
// Latency: expectations are queued at the negedge before the edge that produces them.
// Backpressure: none; stimulus runs in lockstep with the clock.
module tb_decoder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] y;
    logic [2:0] code;
    logic [1:0] state;
    logic       wrap;
    logic       rdy;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Config A: SEL_W=2, DWELL=3, active-high outputs.
  logic       a_rst = 1'b1, a_en = 1'b0, a_mode = 1'b0, a_sv = 1'b0;
  logic [1:0] a_sel = '0;
  logic       a_rdy;
  logic [3:0] a_y;
  logic [1:0] a_code;
  logic [1:0] a_state;
  logic       a_wrap;

  // Config B: SEL_W=3, DWELL=1, active-low outputs.
  logic       b_rst = 1'b1, b_en = 1'b0, b_mode = 1'b0, b_sv = 1'b0;
  logic [2:0] b_sel = '0;
  logic       b_rdy;
  logic [7:0] b_y;
  logic [2:0] b_code;
  logic [1:0] b_state;
  logic       b_wrap;

  decoder_seq #(.SEL_W(2), .DWELL(3), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .sel_valid(a_sv),
    .sel_ready(a_rdy), .sel(a_sel), .y(a_y), .code(a_code), .state(a_state),
    .scan_wrap(a_wrap)
  );

  decoder_seq #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .sel_valid(b_sv),
    .sel_ready(b_rdy), .sel(b_sel), .y(b_y), .code(b_code), .state(b_state),
    .scan_wrap(b_wrap)
  );

  task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s actual=%0h required=%0h", tag, field, act, req);
    end
  endtask

  task automatic a_step(input string tag, input logic r, input logic e, input logic m, input logic v,
                        input logic [1:0] s, input logic [3:0] ey, input logic [1:0] ec,
                        input logic [1:0] est, input logic ew);
    exp_t x;
    @(negedge clk);
    a_rst = r; a_en = e; a_mode = m; a_sv = v; a_sel = s;
    x.name = tag; x.y = {4'b0000, ey}; x.code = {1'b0, ec}; x.state = est; x.wrap = ew; x.rdy = e & ~m;
    qa.push_back(x);
  endtask

  task automatic b_step(input string tag, input logic r, input logic e, input logic m, input logic v,
                        input logic [2:0] s, input logic [7:0] ey, input logic [2:0] ec,
                        input logic [1:0] est, input logic ew);
    exp_t x;
    @(negedge clk);
    b_rst = r; b_en = e; b_mode = m; b_sv = v; b_sel = s;
    x.name = tag; x.y = ey; x.code = ec; x.state = est; x.wrap = ew; x.rdy = e & ~m;
    qb.push_back(x);
  endtask

  // Monitor A: compare each produced cycle against the oldest queued expectation.
  exp_t ma;
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ma = qa.pop_front();
      chk(ma.name, "y",     32'(a_y),     32'(ma.y));
      chk(ma.name, "code",  32'(a_code),  32'(ma.code));
      chk(ma.name, "state", 32'(a_state), 32'(ma.state));
      chk(ma.name, "wrap",  32'(a_wrap),  32'(ma.wrap));
      chk(ma.name, "rdy",   32'(a_rdy),   32'(ma.rdy));
    end
  end

  // Monitor B: same scheme for the active-low configuration.
  exp_t mb;
  always @(posedge clk) begin
    #1;
    if (qb.size() > 0) begin
      mb = qb.pop_front();
      chk(mb.name, "y",     32'(b_y),     32'(mb.y));
      chk(mb.name, "code",  32'(b_code),  32'(mb.code));
      chk(mb.name, "state", 32'(b_state), 32'(mb.state));
      chk(mb.name, "wrap",  32'(b_wrap),  32'(mb.wrap));
      chk(mb.name, "rdy",   32'(b_rdy),   32'(mb.rdy));
    end
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] c;
    logic [7:0] one;

    // ---- Config A ----
    a_step("rst0",   1, 1, 1, 0, 2'd0, 4'b0000, 2'd0, 2'd0, 0);
    a_step("rst1",   1, 1, 1, 0, 2'd0, 4'b0000, 2'd0, 2'd0, 0);
    a_step("rel",    0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 2'd2, 0);
    a_step("dir0",   0, 1, 0, 1, 2'd0, 4'b0001, 2'd0, 2'd1, 0);
    a_step("dir1",   0, 1, 0, 1, 2'd1, 4'b0010, 2'd1, 2'd1, 0);
    a_step("dir2",   0, 1, 0, 1, 2'd2, 4'b0100, 2'd2, 2'd1, 0);
    a_step("dir3",   0, 1, 0, 1, 2'd3, 4'b1000, 2'd3, 2'd1, 0);
    a_step("hold0",  0, 1, 0, 0, 2'd1, 4'b1000, 2'd3, 2'd1, 0);
    a_step("hold1",  0, 1, 0, 0, 2'd2, 4'b1000, 2'd3, 2'd1, 0);
    a_step("dir2b",  0, 1, 0, 1, 2'd2, 4'b0100, 2'd2, 2'd1, 0);
    // SCAN from code 2; sel_valid with sel=1 must be ignored.
    a_step("scan1",  0, 1, 1, 1, 2'd1, 4'b0100, 2'd2, 2'd2, 0);
    a_step("scan2",  0, 1, 1, 1, 2'd1, 4'b0100, 2'd2, 2'd2, 0);
    a_step("scan3",  0, 1, 1, 1, 2'd1, 4'b1000, 2'd3, 2'd2, 0);
    a_step("scan4",  0, 1, 1, 1, 2'd1, 4'b1000, 2'd3, 2'd2, 0);
    a_step("scan5",  0, 1, 1, 1, 2'd1, 4'b1000, 2'd3, 2'd2, 0);
    a_step("scan6",  0, 1, 1, 1, 2'd1, 4'b0001, 2'd0, 2'd2, 1);
    a_step("scan7",  0, 1, 1, 1, 2'd1, 4'b0001, 2'd0, 2'd2, 0);
    a_step("scan8",  0, 1, 1, 1, 2'd1, 4'b0001, 2'd0, 2'd2, 0);
    a_step("scan9",  0, 1, 1, 1, 2'd1, 4'b0010, 2'd1, 2'd2, 0);
    a_step("scan10", 0, 1, 1, 1, 2'd1, 4'b0010, 2'd1, 2'd2, 0);
    // Disable mid-scan at code 1, then re-enable: dwell restarts.
    for (int i = 0; i < 4; i++)
      a_step("off",  0, 0, 1, 0, 2'd0, 4'b0000, 2'd1, 2'd0, 0);
    a_step("on1",    0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 2'd2, 0);
    a_step("on2",    0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 2'd2, 0);
    a_step("on3",    0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 2'd2, 0);
    a_step("on4",    0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 2'd2, 0);
    a_step("on5",    0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 2'd2, 0);
    a_step("on6",    0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 2'd2, 0);
    a_step("on7",    0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 2'd2, 0);
    a_step("on8",    0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 2'd2, 0);
    // code=3, dwell=2: reset must discard the pending wrap.
    a_step("midrst", 1, 1, 1, 0, 2'd0, 4'b0000, 2'd0, 2'd0, 0);
    a_step("rel2",   0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 2'd2, 0);
    a_step("s2d",    0, 1, 0, 0, 2'd3, 4'b0001, 2'd0, 2'd1, 0);
    a_step("doff",   0, 0, 0, 1, 2'd3, 4'b0000, 2'd0, 2'd0, 0);
    a_step("don",    0, 1, 0, 0, 2'd3, 4'b0001, 2'd0, 2'd1, 0);

    // ---- Config B ----
    b_step("brst",   1, 1, 1, 0, 3'd0, 8'hFF, 3'd0, 2'd0, 0);
    for (int k = 1; k <= 17; k++) begin
      c   = 3'(k % 8);
      one = 8'h01 << c;
      b_step("bscan", 0, 1, 1, 0, 3'd0, ~one, c, 2'd2, (c == 3'd0));
    end
    b_step("boff",   0, 0, 1, 0, 3'd0, 8'hFF, 3'd1, 2'd0, 0);
    b_step("bdir5",  0, 1, 0, 1, 3'd5, 8'hDF, 3'd5, 2'd1, 0);
    b_step("bhold",  0, 1, 0, 0, 3'd2, 8'hDF, 3'd5, 2'd1, 0);

    repeat (3) @(negedge clk);
    chk("drain", "qa", 32'(qa.size()), 32'd0);
    chk("drain", "qb", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
